// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC datapath: FSM state encoding,
// the default generator polynomial and the stream-length helper.
package crc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam logic [15:0] CRC16_POLY_DEFAULT = 16'hBAAD;

    // Number of bits streamed through the LFSR: message followed by the tail.
    function automatic int crc_total(input int data_w, input int crc_w);
        return data_w + crc_w;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational single-bit Galois LFSR step. The bit leaving the top of the
// register selects whether the polynomial is folded back in.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_POLY_DEFAULT)
) (
    input  logic [CRC_W-1:0] lfsr,
    input  logic             b,
    output logic [CRC_W-1:0] next_lfsr
);

    // Shift in the stream bit and conditionally apply the polynomial.
    always_comb begin
        next_lfsr = {lfsr[CRC_W-2:0], b} ^ (lfsr[CRC_W-1] ? POLY : '0);
    end

endmodule

// File: rtl/crc_serial_codec.sv
// Bit-serial CRC generator/checker. A message is latched on start and streamed
// MSB-first through a Galois LFSR, followed by CRC_W tail bits; the remainder
// and codeword are registered on the final step and flagged with a done pulse.
// Optional compile-time feature: define CRC_CHECK_EN to add the check mode
// (crc_in / check inputs, crc_ok output).
module crc_serial_codec
    import crc_pkg::*;
#(
    parameter int               DATA_W = 34,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_POLY_DEFAULT),
    parameter logic [CRC_W-1:0] INIT   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_W-1:0]        data_in,
`ifdef CRC_CHECK_EN
    input  logic [CRC_W-1:0]         crc_in,
    input  logic                     check,
    output logic                     crc_ok,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [CRC_W-1:0]         crc_out,
    output logic [DATA_W+CRC_W-1:0]  data_out
);

    localparam int TOTAL = crc_total(DATA_W, CRC_W);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count;
    logic [CRC_W-1:0]   lfsr;
    logic [CRC_W-1:0]   lfsr_next;
    logic [TOTAL-1:0]   stream;
    logic [DATA_W-1:0]  msg_q;
    logic [CRC_W-1:0]   tail;
    logic               accept;
    logic               last_step;

    assign accept    = start && (state_q != SHIFT);
    assign last_step = (state_q == SHIFT) && (count == LAST);

`ifdef CRC_CHECK_EN
    logic               check_q;
    logic [CRC_W-1:0]   crc_q;
    assign tail = check ? crc_in : '0;
`else
    assign tail = '0;
`endif

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .lfsr      (lfsr),
        .b         (stream[TOTAL-1]),
        .next_lfsr (lfsr_next)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start is only honoured outside SHIFT.
    // NOTE: a default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (count == LAST) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state only.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // Datapath: latch on accept, step the LFSR in SHIFT, capture results on the last step.
    // NOTE: every datapath register is reset so an interrupted operation never
    // leaves a partial result visible on the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            lfsr     <= '0;
            stream   <= '0;
            msg_q    <= '0;
            crc_out  <= '0;
            data_out <= '0;
`ifdef CRC_CHECK_EN
            check_q  <= 1'b0;
            crc_q    <= '0;
            crc_ok   <= 1'b0;
`endif
        end else if (accept) begin
            count  <= '0;
            lfsr   <= INIT;
            stream <= {data_in, tail};
            msg_q  <= data_in;
`ifdef CRC_CHECK_EN
            check_q <= check;
            crc_q   <= crc_in;
`endif
        end else if (state_q == SHIFT) begin
            lfsr   <= lfsr_next;
            stream <= {stream[TOTAL-2:0], 1'b0};
            count  <= count + 1'b1;
            if (last_step) begin
                crc_out <= lfsr_next;
`ifdef CRC_CHECK_EN
                data_out <= {msg_q, check_q ? crc_q : lfsr_next};
                crc_ok   <= (lfsr_next == '0);
`else
                data_out <= {msg_q, lfsr_next};
`endif
            end
        end
    end

endmodule

// File: tb/tb_crc_serial_codec.sv
// Directed bench for crc_serial_codec at default parameters. Define
// CRC_CHECK_EN to also exercise the check-mode ports.
module tb_crc_serial_codec;

    localparam int DW    = 34;
    localparam int CW    = 16;
    localparam int TOTAL = DW + CW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DW-1:0]     data_in;
    logic              busy;
    logic              done;
    logic [CW-1:0]     crc_out;
    logic [DW+CW-1:0]  data_out;
`ifdef CRC_CHECK_EN
    logic [CW-1:0]     crc_in;
    logic              check;
    logic              crc_ok;
`endif

    int checks   = 0;
    int failures = 0;

    crc_serial_codec dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
`ifdef CRC_CHECK_EN
        .crc_in   (crc_in),
        .check    (check),
        .crc_ok   (crc_ok),
`endif
        .busy     (busy),
        .done     (done),
        .crc_out  (crc_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (done === 1'b1) break;
        end
    endtask

    // Pulse start for one edge with the given operands and check busy follows.
    task automatic launch(input logic [DW-1:0] d, input logic chk, input logic [CW-1:0] ci);
        data_in = d;
`ifdef CRC_CHECK_EN
        check  = chk;
        crc_in = ci;
`else
        if (chk || (ci != '0)) $display("note: check-mode operands ignored in this build");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Wait for done and check latency, handshake and results.
    task automatic finish_op(input string tag, input logic [CW-1:0] exp_crc,
                             input logic [DW+CW-1:0] exp_data);
        int n;
        wait_done(n);
        check_val({tag, "_done"}, 64'(done), 64'd1);
        check_val({tag, "_latency"}, 64'(n), 64'(TOTAL));
        check_val({tag, "_busy_low"}, 64'(busy), 64'd0);
        check_val({tag, "_crc"}, 64'(crc_out), 64'(exp_crc));
        check_val({tag, "_data"}, 64'(data_out), 64'(exp_data));
    endtask

    initial begin
        int n;
        int done_seen;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
`ifdef CRC_CHECK_EN
        crc_in  = '0;
        check   = 1'b0;
`endif
        repeat (3) tick();
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_crc", 64'(crc_out), 64'd0);
        check_val("rst_data", 64'(data_out), 64'd0);
        reset = 1'b0;
        tick();

        // All-zero message.
        launch(34'h0, 1'b0, 16'h0);
        finish_op("zero", 16'h0000, 50'h0);

        // Single set bit gives the polynomial itself.
        tick();
        launch(34'h1, 1'b0, 16'h0);
        finish_op("one", 16'hBAAD, {34'h1, 16'hBAAD});
`ifdef CRC_CHECK_EN
        check_val("one_crc_ok", 64'(crc_ok), 64'd0);
`endif

        // data=2, then back-to-back start during the DONE cycle.
        tick();
        launch(34'h2, 1'b0, 16'h0);
        finish_op("two", 16'hCFF7, {34'h2, 16'hCFF7});
        data_in = 34'h1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check_val("b2b_busy", 64'(busy), 64'd1);
        check_val("b2b_done_low", 64'(done), 64'd0);
        finish_op("b2b", 16'hBAAD, {34'h1, 16'hBAAD});

        // Reset in the middle of SHIFT.
        tick();
        launch(34'h3, 1'b0, 16'h0);
        repeat (19) tick();
        reset = 1'b1;
        #1;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_done", 64'(done), 64'd0);
        check_val("midrst_crc", 64'(crc_out), 64'd0);
        check_val("midrst_data", 64'(data_out), 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < TOTAL + 10; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check_val("midrst_no_done", 64'(done_seen), 64'd0);
        launch(34'h1, 1'b0, 16'h0);
        finish_op("post_rst", 16'hBAAD, {34'h1, 16'hBAAD});

        // start held through SHIFT with different data: first message wins.
        tick();
        data_in = 34'h1;
        start   = 1'b1;
        tick();
        data_in = 34'h2;
        check_val("held_busy", 64'(busy), 64'd1);
        wait_done(n);
        check_val("held_done", 64'(done), 64'd1);
        check_val("held_latency", 64'(n), 64'(TOTAL));
        check_val("held_crc", 64'(crc_out), 64'hBAAD);
        check_val("held_data", 64'(data_out), 64'({34'h1, 16'hBAAD}));
        start = 1'b0;
        tick();
        check_val("held_idle_busy", 64'(busy), 64'd0);
        check_val("held_idle_done", 64'(done), 64'd0);

`ifdef CRC_CHECK_EN
        // Check mode with matching and corrupted CRC.
        launch(34'h1, 1'b1, 16'hBAAD);
        finish_op("chk_good", 16'h0000, {34'h1, 16'hBAAD});
        check_val("chk_good_ok", 64'(crc_ok), 64'd1);
        tick();
        launch(34'h1, 1'b1, 16'hBAAC);
        finish_op("chk_bad", 16'h0001, {34'h1, 16'hBAAC});
        check_val("chk_bad_ok", 64'(crc_ok), 64'd0);
        tick();
        launch(34'h0, 1'b0, 16'h0);
        finish_op("gen_zero", 16'h0000, 50'h0);
        check_val("gen_zero_ok", 64'(crc_ok), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
